adder_io_pipe: RTL
==================

// Module: adder_io_pipe
// PURPOSE
//  Registered I/O stage around the combinational N-bit adders (RCA, CPA/carry-bypass, etc.).
//  Stage 1 captures operands and drives them to the external adder.
//  Stage 2 captures the adder's sum, cout and overflow.
//  Valid/ready handshake on both sides; back-pressure is supported.
//  A saturating overflow counter is kept for throughput/error benches.
// PARAMETERS
//  N      32  operand/sum width; must be a multiple of 8 (matches the 8-bit adder blocks)
//  CNT_W  16  width of overflow event counter
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  in_valid     in   1      operand pair valid
//  in_ready     out  1      stage 1 can accept
//  in_a         in   N      operand A
//  in_b         in   N      operand B
//  add_a        out  N      stage-1 operand A to adder
//  add_b        out  N      stage-1 operand B to adder
//  add_sum      in   N      adder sum (combinational from add_a/add_b)
//  add_cout     in   1      adder carry-out
//  add_ovf      in   1      adder signed overflow
//  out_valid    out  1      result valid
//  out_ready    in   1      consumer accepts result
//  out_sum      out  N      registered sum
//  out_cout     out  1      registered carry-out
//  out_ovf      out  1      registered overflow
//  ovf_count    out  CNT_W  count of results delivered with out_ovf=1, saturating
// BEHAVIOUR
//  Reset:
//   - Async assert of rst_n clears s1_valid, s2_valid, add_a, add_b, out_sum, out_cout, out_ovf and ovf_count to 0.
//   - Any in-flight data is dropped; there is no partial result.
//  Handshake:
//   - A transfer occurs on a clk edge when valid and ready are both 1.
//   - Once out_valid=1, out_sum, out_cout and out_ovf hold stable until accepted.
//   - out_valid does not drop without a handshake.
//  Advance rules, evaluated each cycle:
//   - s2_take = s1_valid & (~s2_valid | out_ready)
//   - in_ready = ~s1_valid | s2_take  (combinational; no in_valid->in_ready path)
//  Stage 1:
//   - On in_valid & in_ready, load add_a/add_b and set s1_valid=1.
//   - Else if s2_take, clear s1_valid.
//  Stage 2:
//   - On s2_take, load add_sum, add_cout and add_ovf into the out_* registers; set s2_valid=1.
//   - Else if out_ready, clear s2_valid.
//   - out_valid = s2_valid.
//  Latency and throughput:
//   - Accepted in cycle t gives out_valid in cycle t+2.
//   - Throughput is 1 per cycle when out_ready=1 continuously.
//  Simultaneous events:
//   - Load and drain in the same cycle keep the stage full with the new data.
//   - No beat is lost or duplicated.
//  Full condition:
//   - Both stages are valid and out_ready=0, so in_ready=0.
//   - The stall persists until out_ready=1.
//  Arithmetic:
//   - No arithmetic is done here; out_* are exact copies of the adder's outputs.
//   - The adder path is one full cycle (add_a to add_sum is the timed path).
//  Overflow counter:
//   - Increments on (out_valid & out_ready & out_ovf).
//   - Holds at 2^CNT_W-1 and does not wrap.
// STRUCTURE
//  - Shared package adder_pkg holds: ADD_W=32, BLK_W=8 (bypass block width), CNT_W default.
//  - One natural sub-module: pipe_reg_stage (valid/ready register slice, data width param).
//  - It is instantiated twice: N*2 bits in stage 1, N+2 bits in stage 2.
//  - The adder (CPA or RCA) is instantiated by the parent, not inside this block.
// TESTING (bench ties add_* to a CPA instance, N=32)
//  1. Reset mid-flight:
//     - Load 1 pair, assert rst_n=0 before out_valid.
//     - Expect out_valid=0, ovf_count=0; no result after release.
//  2. Single op:
//     - a=0x0000_00FF, b=0x0000_0001, accepted at t.
//     - Expect out_valid at t+2, sum=0x0000_0100, cout=0, ovf=0.
//  3. Bypass/carry extremes:
//     - a=0xFFFF_FFFF, b=0x0000_0001 -> sum=0, cout=1, ovf=0.
//     - a=0x7FFF_FFFF, b=1 -> sum=0x8000_0000, ovf=1, ovf_count=1.
//  4. Back-pressure:
//     - Stream 4 ops with out_ready=0.
//     - Expect in_ready=0 after 2 accepted.
//     - Release: all 4 results in order, none lost or duplicated.
//  5. Full throughput:
//     - 100 random pairs, in_valid=out_ready=1.
//     - Expect 100 results, 1 per cycle, each matching a+b mod 2^32.
//  6. Counter saturation (CNT_W=2):
//     - 5 overflowing ops (0x7FFF_FFFF+1).
//     - Expect ovf_count=3 held.

Source files
------------

// File: rtl/adder_io_pipe_pkg.sv
// ============================================================================
// Module : adder_pkg
// Brief  : Shared widths for the adder I/O pipeline and its adder blocks.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package adder_pkg;

  localparam int ADD_W      = 32;  // default operand/sum width
  localparam int BLK_W      = 8;   // carry-bypass block width; ADD_W must be a multiple
  localparam int CNT_W_DFLT = 16;  // default overflow counter width

endpackage

`default_nettype wire

// File: rtl/adder_io_pipe_if.sv
// ============================================================================
// Module : adder_io_pipe_if
// Brief  : Operand, adder and result bus for adder_io_pipe.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface adder_io_pipe_if #(
  parameter int N     = 32,
  parameter int CNT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_a;
  logic [N-1:0]     in_b;
  logic [N-1:0]     add_a;
  logic [N-1:0]     add_b;
  logic [N-1:0]     add_sum;
  logic             add_cout;
  logic             add_ovf;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic [CNT_W-1:0] ovf_count;

  // Pipeline side
  modport slave (
    input  in_valid, in_a, in_b, add_sum, add_cout, add_ovf, out_ready,
    output in_ready, add_a, add_b, out_valid, out_sum, out_cout, out_ovf, ovf_count
  );

  // Environment side: producer, external adder and consumer
  modport master (
    output in_valid, in_a, in_b, add_sum, add_cout, add_ovf, out_ready,
    input  in_ready, add_a, add_b, out_valid, out_sum, out_cout, out_ovf, ovf_count
  );

endinterface

`default_nettype wire

// File: rtl/adder_io_pipe_stage.sv
// ============================================================================
// Module : pipe_reg_stage
// Brief  : One valid/ready register slice; load wins over drain.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipe_reg_stage #(
  parameter int W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         load,
  input  wire logic         drain,
  input  wire logic [W-1:0] d,
  output logic              valid,
  output logic [W-1:0]      q
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d,  data_q;

  // Load and drain together keep the slice full with the new beat.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

`default_nettype wire

// File: rtl/adder_io_pipe.sv
// ============================================================================
// Module : adder_io_pipe
// Brief  : Registered operand/result stages around an external N-bit adder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module adder_io_pipe
  import adder_pkg::*;
#(
  parameter int N     = ADD_W,       // multiple of BLK_W
  parameter int CNT_W = CNT_W_DFLT
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  adder_io_pipe_if.slave   io
);

  logic             s1_valid;
  logic             s2_valid;
  logic             s1_load;
  logic             s2_take;
  logic [2*N-1:0]   s1_q;
  logic [N+1:0]     s2_q;
  logic [CNT_W-1:0] ovf_count_d, ovf_count_q;

  assign s2_take     = s1_valid & (~s2_valid | io.out_ready);
  assign io.in_ready = ~s1_valid | s2_take;
  assign s1_load     = io.in_valid & io.in_ready;

  pipe_reg_stage #(.W(2*N)) u_stage1 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (s1_load),
    .drain (s2_take),
    .d     ({io.in_a, io.in_b}),
    .valid (s1_valid),
    .q     (s1_q)
  );

  assign io.add_a = s1_q[2*N-1:N];
  assign io.add_b = s1_q[N-1:0];

  // The adder sits between the two slices, so add_a -> add_sum gets a full cycle.
  pipe_reg_stage #(.W(N+2)) u_stage2 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (s2_take),
    .drain (io.out_ready),
    .d     ({io.add_sum, io.add_cout, io.add_ovf}),
    .valid (s2_valid),
    .q     (s2_q)
  );

  assign io.out_valid = s2_valid;
  assign io.out_sum   = s2_q[N+1:2];
  assign io.out_cout  = s2_q[1];
  assign io.out_ovf   = s2_q[0];

  always_comb begin
    ovf_count_d = ovf_count_q;
    if (s2_valid && io.out_ready && io.out_ovf && (ovf_count_q != {CNT_W{1'b1}})) begin
      ovf_count_d = ovf_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count_q <= '0;
    end else begin
      ovf_count_q <= ovf_count_d;
    end
  end

  assign io.ovf_count = ovf_count_q;

endmodule

`default_nettype wire
